// File: rtl/csr_rmw_arbiter.sv
// csr_rmw_arbiter: round-robin arbiter sequencing two requesters onto one CSR port as atomic read-modify-write
module csr_rmw_arbiter #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [1:0]        req0_op,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [1:0]        req1_op,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    output logic              csr_rd,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_dat,
    output logic              csr_wr,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_dat,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, RD, WR, RSP} state_t;
    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_SET   = 2'b10;
    state_t            state_q;
    logic              last_q, owner_q, gnt1, skip_wr;
    logic              csr_rd_q, csr_wr_q, rsp0_valid_q, rsp1_valid_q;
    logic [ADDR_W-1:0] addr_q, addr_d, rd_addr_q, wr_addr_q;
    logic [1:0]        op_q, op_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, old_q, wr_dat_d, wr_dat_q, rsp0_rdata_q, rsp1_rdata_q;
    // Grant, request mux and modify step; on a tie the port that lost last time goes first
    always_comb begin
        gnt1       = req1_valid & (~req0_valid | ~last_q);
        req0_ready = (state_q == IDLE) & req0_valid & ~gnt1;
        req1_ready = (state_q == IDLE) & gnt1;
        addr_d     = gnt1 ? req1_addr : req0_addr;
        op_d       = gnt1 ? req1_op : req0_op;
        wdata_d    = gnt1 ? req1_wdata : req0_wdata;
        skip_wr    = (op_q == OP_READ) | (op_q[1] & (wdata_q == '0));
        wr_dat_d   = (op_q == OP_WRITE) ? wdata_q : (op_q == OP_SET) ? (rd_dat | wdata_q) : (rd_dat & ~wdata_q);
    end
    // Sequencer with registered outputs; strobes default low so each lasts exactly one state
    always_ff @(posedge clk) begin
        csr_rd_q     <= 1'b0;
        rd_addr_q    <= '0;
        csr_wr_q     <= 1'b0;
        wr_addr_q    <= '0;
        wr_dat_q     <= '0;
        rsp0_valid_q <= 1'b0;
        rsp0_rdata_q <= '0;
        rsp1_valid_q <= 1'b0;
        rsp1_rdata_q <= '0;
        if (reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
        end else begin
            case (state_q)
                IDLE: if (req0_ready | req1_ready) begin
                    state_q   <= RD;
                    owner_q   <= gnt1;
                    last_q    <= gnt1;
                    addr_q    <= addr_d;
                    op_q      <= op_d;
                    wdata_q   <= wdata_d;
                    csr_rd_q  <= 1'b1;
                    rd_addr_q <= addr_d;
                end
                RD: begin
                    old_q        <= rd_dat;
                    state_q      <= skip_wr ? RSP : WR;
                    csr_wr_q     <= ~skip_wr;
                    wr_addr_q    <= skip_wr ? '0 : addr_q;
                    wr_dat_q     <= skip_wr ? '0 : wr_dat_d;
                    rsp0_valid_q <= skip_wr & ~owner_q;
                    rsp0_rdata_q <= (skip_wr & ~owner_q) ? rd_dat : '0;
                    rsp1_valid_q <= skip_wr & owner_q;
                    rsp1_rdata_q <= (skip_wr & owner_q) ? rd_dat : '0;
                end
                WR: begin
                    state_q      <= RSP;
                    rsp0_valid_q <= ~owner_q;
                    rsp0_rdata_q <= owner_q ? '0 : old_q;
                    rsp1_valid_q <= owner_q;
                    rsp1_rdata_q <= owner_q ? old_q : '0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign csr_rd     = csr_rd_q;
    assign rd_addr    = rd_addr_q;
    assign csr_wr     = csr_wr_q;
    assign wr_addr    = wr_addr_q;
    assign wr_dat     = wr_dat_q;
    assign rsp0_valid = rsp0_valid_q;
    assign rsp0_rdata = rsp0_rdata_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp1_rdata = rsp1_rdata_q;
    assign busy       = state_q != IDLE;
endmodule

// File: tb/tb_csr_rmw_arbiter.sv
// tb_csr_rmw_arbiter: directed vectors, corner sequences and randomized traffic against a transaction-level model
module tb_csr_rmw_arbiter;
    logic        clk, reset;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [11:0] req0_addr, req1_addr, rd_addr, wr_addr;
    logic [1:0]  req0_op, req1_op;
    logic [31:0] req0_wdata, req1_wdata, rsp0_rdata, rsp1_rdata, rd_dat, wr_dat;
    logic        rsp0_valid, rsp1_valid, csr_rd, csr_wr, busy;

    csr_rmw_arbiter dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr),
        .req0_op(req0_op), .req0_wdata(req0_wdata), .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr),
        .req1_op(req1_op), .req1_wdata(req1_wdata), .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
        .csr_rd(csr_rd), .rd_addr(rd_addr), .rd_dat(rd_dat),
        .csr_wr(csr_wr), .wr_addr(wr_addr), .wr_dat(wr_dat), .busy(busy)
    );

    typedef struct {
        bit          port;
        logic [11:0] addr;
        logic [1:0]  op;
        logic [31:0] wdata;
        bit          pre;
        logic [31:0] init;
        logic [31:0] exp_rdata;
        logic [31:0] exp_final;
        int          lat;
    } vec_t;

    int n_cmp = 0, n_bad = 0, cyc = 0;
    bit [31:0] mem [4096];
    bit [31:0] ref_mem [4096];
    logic        pre_en = 1'b0;
    logic [11:0] pre_addr = '0;
    logic [31:0] pre_val = '0;
    bit model_on = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // CSR file: combinational read, write committed on the clock edge
    assign rd_dat = mem[rd_addr];
    always @(posedge clk) begin
        if (csr_wr) mem[wr_addr] <= wr_dat;
        if (pre_en) mem[pre_addr] <= pre_val;
    end

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Transaction-level model: one outstanding request, with its read/write/response cycles scheduled from the handshake
    int rd_cyc = -1, wr_cyc = -1, rsp_cyc = -1, idle_cyc = 0;
    bit m_last = 1'b1, idle, gnt, e_r0, e_r1, e_rd, e_wr, e_rsp, t_own, t_wr;
    logic [11:0] t_addr = '0;
    logic [1:0]  t_op;
    logic [31:0] t_wdata, t_old = '0, t_new = '0;
    initial begin
        forever begin
            @(negedge clk);
            if (pre_en) ref_mem[pre_addr] = pre_val;
            if (model_on) begin
                idle  = cyc >= idle_cyc;
                gnt   = (req0_valid && req1_valid) ? !m_last : req1_valid;
                e_r0  = idle && req0_valid && !gnt;
                e_r1  = idle && req1_valid && gnt;
                e_rd  = cyc == rd_cyc;
                e_wr  = cyc == wr_cyc;
                e_rsp = cyc == rsp_cyc;
                chk("req0_ready", 64'(req0_ready), 64'(e_r0));
                chk("req1_ready", 64'(req1_ready), 64'(e_r1));
                chk("busy", 64'(busy), 64'(!idle));
                chk("csr_rd", 64'(csr_rd), 64'(e_rd));
                chk("rd_addr", 64'(rd_addr), 64'(e_rd ? t_addr : 12'h0));
                chk("csr_wr", 64'(csr_wr), 64'(e_wr));
                chk("wr_addr", 64'(wr_addr), 64'(e_wr ? t_addr : 12'h0));
                chk("wr_dat", 64'(wr_dat), 64'(e_wr ? t_new : 32'h0));
                chk("rsp0_valid", 64'(rsp0_valid), 64'(e_rsp && !t_own));
                chk("rsp0_rdata", 64'(rsp0_rdata), 64'((e_rsp && !t_own) ? t_old : 32'h0));
                chk("rsp1_valid", 64'(rsp1_valid), 64'(e_rsp && t_own));
                chk("rsp1_rdata", 64'(rsp1_rdata), 64'((e_rsp && t_own) ? t_old : 32'h0));
                if (e_wr) ref_mem[t_addr] = t_new;
                if (reset) begin
                    idle_cyc = cyc + 1;
                    rd_cyc   = -1;
                    wr_cyc   = -1;
                    rsp_cyc  = -1;
                    m_last   = 1'b1;
                end else if (e_r0 || e_r1) begin
                    t_own    = e_r1;
                    t_addr   = t_own ? req1_addr : req0_addr;
                    t_op     = t_own ? req1_op : req0_op;
                    t_wdata  = t_own ? req1_wdata : req0_wdata;
                    t_old    = ref_mem[t_addr];
                    t_new    = (t_op == 2'd1) ? t_wdata : (t_op == 2'd2) ? (t_old | t_wdata) : (t_old & ~t_wdata);
                    t_wr     = (t_op == 2'd1) || (t_op[1] && t_wdata != 0);
                    rd_cyc   = cyc + 1;
                    wr_cyc   = t_wr ? cyc + 2 : -1;
                    rsp_cyc  = cyc + (t_wr ? 3 : 2);
                    idle_cyc = rsp_cyc + 1;
                    m_last   = t_own;
                end
            end
        end
    end

    task automatic idle_inputs();
        req0_valid = 0; req0_addr = '0; req0_op = '0; req0_wdata = '0;
        req1_valid = 0; req1_addr = '0; req1_op = '0; req1_wdata = '0;
    endtask

    task automatic drive(input bit port, input logic [11:0] a, input logic [1:0] op, input logic [31:0] wd);
        if (port) begin
            req1_valid = 1; req1_addr = a; req1_op = op; req1_wdata = wd;
        end else begin
            req0_valid = 1; req0_addr = a; req0_op = op; req0_wdata = wd;
        end
    endtask

    task automatic preload(input logic [11:0] a, input logic [31:0] v);
        @(posedge clk); #1;
        pre_en = 1; pre_addr = a; pre_val = v;
        @(posedge clk); #1;
        pre_en = 0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1 reset = 0;
    endtask

    task automatic run_vec(input vec_t v);
        bit got;
        int lat;
        logic [31:0] rd;
        if (v.pre) preload(v.addr, v.init);
        @(posedge clk); #1;
        drive(v.port, v.addr, v.op, v.wdata);
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            got = v.port ? req1_ready : req0_ready;
        end
        chk("vec_handshake", 64'(got), 64'(1));
        @(posedge clk); #1;
        idle_inputs();
        got = 0; lat = 0; rd = '0;
        for (int i = 1; i <= 8 && !got; i++) begin
            @(negedge clk);
            if (v.port ? rsp1_valid : rsp0_valid) begin
                got = 1; lat = i; rd = v.port ? rsp1_rdata : rsp0_rdata;
            end
        end
        chk("vec_latency", 64'(lat), 64'(v.lat));
        chk("vec_rdata", 64'(rd), 64'(v.exp_rdata));
        repeat (2) @(negedge clk);
        chk("vec_final", 64'(mem[v.addr]), 64'(v.exp_final));
    endtask

    vec_t vecs[10];
    int grants[$];
    bit seen;

    initial begin
        vecs[0] = '{port:0, addr:12'h300, op:2'd0, wdata:32'h0,        pre:1, init:32'hA5,        exp_rdata:32'hA5,        exp_final:32'hA5,        lat:2};
        vecs[1] = '{port:1, addr:12'h305, op:2'd2, wdata:32'h0F,       pre:1, init:32'hF0,        exp_rdata:32'hF0,        exp_final:32'hFF,        lat:3};
        vecs[2] = '{port:1, addr:12'h305, op:2'd3, wdata:32'hF0,       pre:0, init:32'h0,         exp_rdata:32'hFF,        exp_final:32'h0F,        lat:3};
        vecs[3] = '{port:0, addr:12'h310, op:2'd2, wdata:32'h0,        pre:1, init:32'h55,        exp_rdata:32'h55,        exp_final:32'h55,        lat:2};
        vecs[4] = '{port:0, addr:12'h340, op:2'd1, wdata:32'h1234,     pre:1, init:32'hDEAD,      exp_rdata:32'hDEAD,      exp_final:32'h1234,      lat:3};
        vecs[5] = '{port:1, addr:12'h340, op:2'd0, wdata:32'h0,        pre:0, init:32'h0,         exp_rdata:32'h1234,      exp_final:32'h1234,      lat:2};
        vecs[6] = '{port:1, addr:12'h311, op:2'd3, wdata:32'h0,        pre:1, init:32'h3C,        exp_rdata:32'h3C,        exp_final:32'h3C,        lat:2};
        vecs[7] = '{port:0, addr:12'h312, op:2'd1, wdata:32'h0,        pre:1, init:32'hFFFFFFFF,  exp_rdata:32'hFFFFFFFF,  exp_final:32'h0,         lat:3};
        vecs[8] = '{port:1, addr:12'h313, op:2'd3, wdata:32'hFFFF0000, pre:1, init:32'h12345678,  exp_rdata:32'h12345678,  exp_final:32'h5678,      lat:3};
        vecs[9] = '{port:0, addr:12'h314, op:2'd2, wdata:32'h80000001, pre:1, init:32'h100,       exp_rdata:32'h100,       exp_final:32'h80000101,  lat:3};
        reset = 1;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1 reset = 0;
        model_on = 1;
        @(negedge clk);
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_csr_rd", 64'(csr_rd), 64'(0));
        for (int i = 0; i < 10; i++) run_vec(vecs[i]);

        // Both ports requesting continuously: grants alternate starting with port 0
        do_reset();
        @(posedge clk); #1;
        drive(0, 12'h300, 2'd0, 32'h0);
        drive(1, 12'h301, 2'd0, 32'h0);
        grants.delete();
        repeat (14) begin
            @(negedge clk);
            if (req0_ready) grants.push_back(0);
            if (req1_ready) grants.push_back(1);
        end
        @(posedge clk); #1;
        idle_inputs();
        chk("t3_grant_count", 64'(grants.size()), 64'(5));
        for (int i = 0; i < 4; i++) chk("t3_grant_order", 64'(i < grants.size() ? grants[i] : 9), 64'(i % 2));
        repeat (4) @(negedge clk);

        // Reset while a write is pending (in RD): no write, no response, quiet outputs afterwards
        preload(12'h350, 32'h77);
        @(posedge clk); #1;
        drive(0, 12'h350, 2'd1, 32'h99);
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = req0_ready;
        end
        chk("t5_handshake", 64'(seen), 64'(1));
        @(posedge clk); #1;
        idle_inputs();
        reset = 1;
        @(negedge clk);
        chk("t5_rd_during_reset", 64'(csr_rd), 64'(1));
        @(posedge clk); #1;
        reset = 0;
        @(negedge clk);
        chk("t5_busy", 64'(busy), 64'(0));
        chk("t5_csr_wr", 64'(csr_wr), 64'(0));
        chk("t5_wr_dat", 64'(wr_dat), 64'(0));
        chk("t5_rsp0", 64'(rsp0_valid), 64'(0));
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            seen = seen | csr_wr | rsp0_valid | rsp1_valid;
        end
        chk("t5_no_activity", 64'(seen), 64'(0));
        chk("t5_mem_kept", 64'(mem[12'h350]), 64'(32'h77));

        // Randomized traffic on a few shared addresses, with occasional resets
        for (int a = 0; a < 4; a++) preload(12'h300 + 12'(a), $urandom);
        for (int i = 0; i < 800; i++) begin
            @(posedge clk); #1;
            reset      = $urandom_range(0, 99) == 0;
            req0_valid = $urandom_range(0, 2) != 0;
            req0_addr  = 12'h300 + 12'($urandom_range(0, 3));
            req0_op    = 2'($urandom_range(0, 3));
            req0_wdata = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            req1_valid = $urandom_range(0, 2) != 0;
            req1_addr  = 12'h300 + 12'($urandom_range(0, 3));
            req1_op    = 2'($urandom_range(0, 3));
            req1_wdata = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
        end
        @(posedge clk); #1;
        reset = 0;
        idle_inputs();
        repeat (6) @(negedge clk);
        for (int a = 12'h300; a < 12'h360; a++) chk("final_csr", 64'(mem[a]), 64'(ref_mem[a]));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
